// File: rtl/uart_regs.sv
// 8N1 UART on the lisp_core register bus: DATA (TX write / RX read) and STATUS.
// Define UART_RX_FIFO_EN for a 4-entry RX FIFO instead of a single holding register.
module uart_regs #(
    parameter int CLKS_PER_BIT = 434,
    parameter int BASE_INDEX   = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [6:0]  register_index,
    input  logic        register_read,
    input  logic        register_write,
    input  logic [15:0] register_write_value,
    output logic [15:0] register_read_value,
    output logic        uart_tx,
    input  logic        uart_rx
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] TICK_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] TICK_HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [6:0]    DATA_IDX  = 7'(BASE_INDEX);
    localparam logic [6:0]    STAT_IDX  = 7'(BASE_INDEX + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic w_data_sel;
    logic w_stat_sel;
    logic w_unused;

    assign w_data_sel = (register_index == DATA_IDX);
    assign w_stat_sel = (register_index == STAT_IDX);
    assign w_unused   = ^register_write_value[15:8];

    // ---------------- TX ----------------
    state_t        r_tx_state;
    state_t        w_tx_next;
    logic [CW-1:0] r_tx_cnt;
    logic [2:0]    r_tx_bit;
    logic [7:0]    r_tx_shift;
    logic          r_tx;
    logic          w_tx_tick;
    logic          w_tx_load;
    logic          w_tx_busy;

    assign w_tx_tick = (r_tx_cnt == TICK_LAST);
    assign w_tx_busy = (r_tx_state != S_IDLE);
    // A write landing on the final stop-bit cycle chains straight into the next frame
    assign w_tx_load = register_write && w_data_sel &&
                       ((r_tx_state == S_IDLE) ||
                        (r_tx_state == S_STOP && w_tx_tick));
    assign uart_tx   = r_tx;

    always_comb begin
        w_tx_next = r_tx_state;
        case (r_tx_state)
            S_IDLE:  if (w_tx_load) w_tx_next = S_START;
            S_START: if (w_tx_tick) w_tx_next = S_DATA;
            S_DATA:  if (w_tx_tick && r_tx_bit == 3'd7) w_tx_next = S_STOP;
            S_STOP: begin
                if (w_tx_load)      w_tx_next = S_START;
                else if (w_tx_tick) w_tx_next = S_IDLE;
            end
            default: w_tx_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_tx_state <= S_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= 3'd0;
            r_tx_shift <= 8'h00;
            r_tx       <= 1'b1;
        end else begin
            r_tx_state <= w_tx_next;
            if (w_tx_load) begin
                r_tx_shift <= register_write_value[7:0];
                r_tx_cnt   <= '0;
                r_tx_bit   <= 3'd0;
                r_tx       <= 1'b0;
            end else if (r_tx_state != S_IDLE) begin
                if (w_tx_tick) begin
                    r_tx_cnt <= '0;
                    case (r_tx_state)
                        S_START: r_tx <= r_tx_shift[0];
                        S_DATA: begin
                            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                            r_tx_bit   <= r_tx_bit + 3'd1;
                            r_tx       <= (r_tx_bit == 3'd7) ? 1'b1 : r_tx_shift[1];
                        end
                        default: r_tx <= 1'b1;
                    endcase
                end else begin
                    r_tx_cnt <= r_tx_cnt + CNT_ONE;
                end
            end
        end
    end

    // ---------------- RX ----------------
    logic          r_rx_s1;
    logic          r_rx_s2;
    logic          r_rx_d;
    state_t        r_rx_state;
    state_t        w_rx_next;
    logic [CW-1:0] r_rx_cnt;
    logic [2:0]    r_rx_bit;
    logic [7:0]    r_rx_shift;
    logic          w_rx_fall;
    logic          w_rx_tick;
    logic          w_rx_half;
    logic          w_push;

    assign w_rx_fall = r_rx_d & ~r_rx_s2;
    assign w_rx_tick = (r_rx_cnt == TICK_LAST);
    assign w_rx_half = (r_rx_cnt == TICK_HALF);
    assign w_push    = (r_rx_state == S_STOP) && w_rx_tick && r_rx_s2;

    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            S_IDLE:  if (w_rx_fall) w_rx_next = S_START;
            S_START: if (w_rx_half) w_rx_next = r_rx_s2 ? S_IDLE : S_DATA;
            S_DATA:  if (w_rx_tick && r_rx_bit == 3'd7) w_rx_next = S_STOP;
            S_STOP:  if (w_rx_tick) w_rx_next = S_IDLE;
            default: w_rx_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_d     <= 1'b1;
            r_rx_state <= S_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= 3'd0;
            r_rx_shift <= 8'h00;
        end else begin
            r_rx_s1    <= uart_rx;
            r_rx_s2    <= r_rx_s1;
            r_rx_d     <= r_rx_s2;
            r_rx_state <= w_rx_next;
            if (r_rx_state == S_IDLE || w_rx_tick ||
                (r_rx_state == S_START && w_rx_half))
                r_rx_cnt <= '0;
            else
                r_rx_cnt <= r_rx_cnt + CNT_ONE;
            if (r_rx_state == S_START)
                r_rx_bit <= 3'd0;
            if (r_rx_state == S_DATA && w_rx_tick) begin
                r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                r_rx_bit   <= r_rx_bit + 3'd1;
            end
        end
    end

    // ---------------- RX storage ----------------
    logic       w_pop;
    logic       w_stat_rd;
    logic       w_rx_valid;
    logic       w_rx_full;
    logic [7:0] w_rx_head;
    logic       w_push_ok;
    logic       r_ovr;

    assign w_pop     = register_read && w_data_sel && w_rx_valid;
    assign w_stat_rd = register_read && w_stat_sel;
    assign w_push_ok = w_push && (!w_rx_full || w_pop);

`ifdef UART_RX_FIFO_EN
    logic [7:0] r_mem [4];
    logic [1:0] r_wp;
    logic [1:0] r_rp;
    logic [2:0] r_cnt;

    assign w_rx_valid = (r_cnt != 3'd0);
    assign w_rx_full  = (r_cnt == 3'd4);
    assign w_rx_head  = r_mem[r_rp];

    always_ff @(posedge clk) begin
        if (w_push_ok)
            r_mem[r_wp] <= r_rx_shift;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wp  <= 2'd0;
            r_rp  <= 2'd0;
            r_cnt <= 3'd0;
        end else begin
            if (w_push_ok) r_wp <= r_wp + 2'd1;
            if (w_pop)     r_rp <= r_rp + 2'd1;
            case ({w_push_ok, w_pop})
                2'b10:   r_cnt <= r_cnt + 3'd1;
                2'b01:   r_cnt <= r_cnt - 3'd1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end
`else
    logic [7:0] r_hold;
    logic       r_hold_v;

    assign w_rx_valid = r_hold_v;
    assign w_rx_full  = r_hold_v;
    assign w_rx_head  = r_hold;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_hold   <= 8'h00;
            r_hold_v <= 1'b0;
        end else if (w_push_ok) begin
            r_hold   <= r_rx_shift;
            r_hold_v <= 1'b1;
        end else if (w_pop) begin
            r_hold_v <= 1'b0;
        end
    end
`endif

    // A fresh overrun outranks a simultaneous STATUS-read clear
    always_ff @(posedge clk) begin
        if (!reset_n)
            r_ovr <= 1'b0;
        else if (w_push && w_rx_full && !w_pop)
            r_ovr <= 1'b1;
        else if (w_stat_rd)
            r_ovr <= 1'b0;
    end

    always_comb begin
        register_read_value = 16'h0000;
        if (w_data_sel)
            register_read_value = {8'h00, w_rx_valid ? w_rx_head : 8'h00};
        else if (w_stat_sel)
            register_read_value = {13'd0, r_ovr, w_rx_valid, w_tx_busy};
    end

endmodule

// File: tb/tb_uart_regs.sv
// Directed bench for uart_regs at 8 clocks per bit.
// Covers reset, TX framing/busy, RX, overrun, framing error, glitch, reset mid-frame.
module tb_uart_regs;

    localparam int CPB = 8;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [6:0]  register_index;
    logic        register_read;
    logic        register_write;
    logic [15:0] register_write_value;
    logic [15:0] register_read_value;
    logic        uart_tx;
    logic        uart_rx;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_regs #(
        .CLKS_PER_BIT(CPB),
        .BASE_INDEX  (8)
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .register_index      (register_index),
        .register_read       (register_read),
        .register_write      (register_write),
        .register_write_value(register_write_value),
        .register_read_value (register_read_value),
        .uart_tx             (uart_tx),
        .uart_rx             (uart_rx)
    );

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic rd(input logic [6:0] idx, input logic [15:0] exp,
                      input string tag);
        register_index = idx;
        register_read  = 1'b1;
        #1 check(tag, register_read_value, exp);
        @(negedge clk);
        register_read = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input logic stopb);
        logic [9:0] fr;
        fr = {stopb, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            uart_rx = fr[k];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    initial begin
        logic [9:0] frame;
        logic       exp_tx;
        int         busy_cycles;

        reset_n              = 1'b0;
        register_index       = 7'd0;
        register_read        = 1'b0;
        register_write       = 1'b0;
        register_write_value = 16'h0000;
        uart_rx              = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        check("reset_tx", {15'd0, uart_tx}, 16'h0001);
        rd(7'd9, 16'h0000, "reset_status");
        rd(7'd8, 16'h0000, "reset_data");

        // TX 0x55; a second write mid-frame must be dropped
        frame                = {1'b1, 8'h55, 1'b0};
        busy_cycles          = 0;
        register_index       = 7'd8;
        register_write_value = 16'h1255;
        register_write       = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 90; i++) begin
            register_write = 1'b0;
            register_index = 7'd9;
            #1;
            exp_tx = (i < 80) ? frame[i / 8] : 1'b1;
            check("tx_bit", {15'd0, uart_tx}, {15'd0, exp_tx});
            if (register_read_value[0]) busy_cycles++;
            if (i == 20) begin
                register_index       = 7'd8;
                register_write_value = 16'h00AA;
                register_write       = 1'b1;
            end
            @(negedge clk);
        end
        register_write = 1'b0;
        check("tx_busy_cycles", 16'(busy_cycles), 16'd80);

        // RX single byte
        send(8'hA3, 1'b1);
        rd(7'd9, 16'h0002, "rx_status_valid");
        rd(7'd8, 16'h00A3, "rx_data");
        rd(7'd9, 16'h0000, "rx_status_empty");

`ifdef UART_RX_FIFO_EN
        for (int b = 1; b <= 5; b++) send(8'(b), 1'b1);
        rd(7'd9, 16'h0006, "ovr_status");
        rd(7'd8, 16'h0001, "fifo_rd1");
        rd(7'd8, 16'h0002, "fifo_rd2");
        rd(7'd8, 16'h0003, "fifo_rd3");
        rd(7'd8, 16'h0004, "fifo_rd4");
        rd(7'd9, 16'h0000, "ovr_cleared");
`else
        send(8'h01, 1'b1);
        send(8'h02, 1'b1);
        rd(7'd9, 16'h0006, "ovr_status");
        rd(7'd8, 16'h0001, "ovr_data");
        rd(7'd9, 16'h0000, "ovr_cleared");
`endif

        // Framing error and start-bit glitch push nothing
        send(8'h5A, 1'b0);
        rd(7'd9, 16'h0000, "framing_err");
        uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        repeat (20) @(negedge clk);
        rd(7'd9, 16'h0000, "glitch");
        rd(7'd3, 16'h0000, "foreign_idx");
        rd(7'd8, 16'h0000, "empty_data");

        // Reset in the middle of a TX and an RX frame
        register_index       = 7'd8;
        register_write_value = 16'h0000;
        register_write       = 1'b1;
        uart_rx              = 1'b0;
        @(negedge clk);
        register_write = 1'b0;
        repeat (20) @(negedge clk);
        check("mid_tx_low", {15'd0, uart_tx}, 16'h0000);
        reset_n = 1'b0;
        @(negedge clk);
        register_index = 7'd9;
        #1;
        check("mid_reset_tx", {15'd0, uart_tx}, 16'h0001);
        check("mid_reset_status", register_read_value, 16'h0000);
        @(negedge clk);
        reset_n = 1'b1;
        uart_rx = 1'b1;
        repeat (100) @(negedge clk);
        rd(7'd9, 16'h0000, "post_reset_status");
        check("post_reset_tx", {15'd0, uart_tx}, 16'h0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
